// File: rtl/flight_pkg.sv
// Shared game geometry, FSM states and small geometry helpers for the
// flight engine and the VGA colouring controller.
package flight_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_e;

  localparam logic [9:0] SCREEN_W   = 10'd640;
  localparam logic [9:0] SCREEN_H   = 10'd480;
  localparam logic [9:0] PLANE_X    = 10'd100;
  localparam logic [9:0] PLANE_SIZE = 10'd16;
  localparam logic [9:0] MTN_W      = 10'd30;
  localparam logic [9:0] SCROLL     = 10'd2;

  localparam logic signed [5:0] GRAVITY  = 6'sd1;
  localparam logic signed [5:0] FLAP_V   = 6'sd6;
  localparam logic signed [5:0] MAX_FALL = 6'sd8;

  localparam logic [9:0] INIT_PLANE_Y = 10'd240;
  localparam logic [9:0] INIT_M1_X    = 10'd400;
  localparam logic [9:0] INIT_M1_Y    = 10'd320;
  localparam logic [9:0] INIT_M2_X    = 10'd720;
  localparam logic [9:0] INIT_M2_Y    = 10'd360;
  localparam logic [9:0] INIT_LAVA_X  = 10'd640;
  localparam logic [9:0] MTN_Y_BASE   = 10'd240;

  // Move left by step; objects that would go negative re-enter at the right.
  function automatic logic [9:0] scroll_x(input logic [9:0] x,
                                          input logic [9:0] step);
    return (x >= step) ? x - step : SCREEN_W;
  endfunction

  // Mountain right edge crosses from at/after the plane to strictly before.
  function automatic logic passed(input logic [9:0] x,
                                  input logic [9:0] xn);
    logic [10:0] r0;
    logic [10:0] r1;
    r0 = {1'b0, x} + {1'b0, MTN_W};
    r1 = {1'b0, xn} + {1'b0, MTN_W};
    return (r0 >= {1'b0, PLANE_X}) && (r1 < {1'b0, PLANE_X});
  endfunction

  // Inclusive overlap of [a0, a0+aw] and [b0, b0+bw].
  function automatic logic overlap(input logic [9:0] a0,
                                   input logic [9:0] aw,
                                   input logic [9:0] b0,
                                   input logic [9:0] bw);
    logic [10:0] a1;
    logic [10:0] b1;
    a1 = {1'b0, a0} + {1'b0, aw};
    b1 = {1'b0, b0} + {1'b0, bw};
    return ({1'b0, a0} <= b1) && ({1'b0, b0} <= a1);
  endfunction

endpackage

// File: rtl/flight_engine_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4), seed 8'hA5, advances when en_i.
// Ports: clk, reset (sync, active-high), en_i, q_o (current state).
module lfsr8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  output logic [7:0] q_o
);

  logic [7:0] q_q;
  logic [7:0] q_d;

  // Maximal-length taps: the all-zero state is never entered from A5.
  assign q_d = {q_q[6:0], ^(q_q & 8'hB8)};
  assign q_o = q_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= 8'hA5;
    end else if (en_i) begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/flight_engine.sv
// Per-frame game physics: plane altitude, scrolling mountains/lava,
// collision and score. Ports: clk, reset, frame_tick, flap, start in;
// plane_y, mountain1_x/y, mountain2_x/y, lava_x, game_over, score out.
// Optional FLIGHT_ENGINE_LAVA_HIT_EN makes the lava box a collision source.
module flight_engine
  import flight_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       flap,
  input  logic       start,
  output logic [9:0] plane_y,
  output logic [9:0] mountain1_x,
  output logic [9:0] mountain1_y,
  output logic [9:0] mountain2_x,
  output logic [9:0] mountain2_y,
  output logic [9:0] lava_x,
  output logic       game_over,
  output logic [7:0] score
);

  state_e            state_q;
  logic [9:0]        py_q, m1x_q, m1y_q, m2x_q, m2y_q, lx_q;
  logic signed [5:0] vel_q;
  logic [7:0]        score_q;
  logic              over_q, pend_q, flap_q;

  logic [7:0]        rnd, rnd_rot;
  logic              upd, flap_rise, reinit;
  logic signed [5:0] vel_d;
  logic [10:0]       y_raw;
  logic              floor_hit, m1_hit, m2_hit, lava_hit, hit;
  logic [9:0]        py_d, m1x_d, m1y_d, m2x_d, m2y_d, lx_d;
  logic [1:0]        passes;
  logic [8:0]        score_sum;
  logic [7:0]        score_d;

  assign upd       = (state_q == PLAY) && frame_tick;
  assign flap_rise = flap && !flap_q;
  assign reinit    = reset || ((state_q == OVER) && start);
  assign rnd_rot   = {rnd[4:0], rnd[7:5]};

  lfsr8 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en_i  (upd),
    .q_o   (rnd)
  );

  always_comb begin
    vel_d = MAX_FALL;
    if (pend_q) begin
      vel_d = -FLAP_V;
    end else if (vel_q < MAX_FALL - GRAVITY) begin
      vel_d = vel_q + GRAVITY;
    end
    // plane_y <= 463 and vel >= -6, so bit 10 set means negative
    y_raw = {1'b0, py_q} + {{5{vel_d[5]}}, vel_d};
    floor_hit = !y_raw[10] &&
                (y_raw >= {1'b0, SCREEN_H - PLANE_SIZE});
    py_d = y_raw[9:0];
    if (y_raw[10]) begin
      py_d = 10'd0;
    end else if (floor_hit) begin
      py_d = SCREEN_H - PLANE_SIZE - 10'd1;
    end
  end

  always_comb begin
    m1x_d = scroll_x(m1x_q, SCROLL);
    m2x_d = scroll_x(m2x_q, SCROLL);
    lx_d  = scroll_x(lx_q, SCROLL + SCROLL);
    m1y_d = m1y_q;
    m2y_d = m2y_q;
    if (m1x_q < SCROLL) begin
      m1y_d = MTN_Y_BASE + {3'b0, rnd[6:0]};
    end
    if (m2x_q < SCROLL) begin
      m2y_d = MTN_Y_BASE + {3'b0, rnd_rot[6:0]};
    end
    passes = {1'b0, passed(m1x_q, m1x_d)} +
             {1'b0, passed(m2x_q, m2x_d)};
    score_sum = {1'b0, score_q} + {7'b0, passes};
    score_d = score_sum[8] ? 8'hFF : score_sum[7:0];
  end

  // Mountains extend from their top row to the bottom of the screen.
  assign m1_hit = overlap(PLANE_X, PLANE_SIZE, m1x_d, MTN_W) &&
                  overlap(py_d, PLANE_SIZE, m1y_d, SCREEN_H - m1y_d);
  assign m2_hit = overlap(PLANE_X, PLANE_SIZE, m2x_d, MTN_W) &&
                  overlap(py_d, PLANE_SIZE, m2y_d, SCREEN_H - m2y_d);

`ifdef FLIGHT_ENGINE_LAVA_HIT_EN
  localparam logic [9:0] LAVA_Y = 10'd100;
  // Extra 15 rows cover the controller's random vertical jitter.
  localparam logic [9:0] LAVA_H = PLANE_SIZE + 10'd15;
  assign lava_hit = overlap(PLANE_X, PLANE_SIZE, lx_d, PLANE_SIZE) &&
                    overlap(py_d, PLANE_SIZE, LAVA_Y, LAVA_H);
`else
  assign lava_hit = 1'b0;
`endif

  assign hit = floor_hit || m1_hit || m2_hit || lava_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      flap_q <= 1'b0;
    end else begin
      flap_q <= flap;
    end
  end

  always_ff @(posedge clk) begin
    if (reinit) begin
      state_q <= IDLE;
      py_q    <= INIT_PLANE_Y;
      vel_q   <= 6'sd0;
      m1x_q   <= INIT_M1_X;
      m1y_q   <= INIT_M1_Y;
      m2x_q   <= INIT_M2_X;
      m2y_q   <= INIT_M2_Y;
      lx_q    <= INIT_LAVA_X;
      score_q <= 8'd0;
      over_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          pend_q <= 1'b0;
          if (start) begin
            state_q <= PLAY;
          end
        end
        PLAY: begin
          if (frame_tick) begin
            py_q    <= py_d;
            vel_q   <= vel_d;
            m1x_q   <= m1x_d;
            m1y_q   <= m1y_d;
            m2x_q   <= m2x_d;
            m2y_q   <= m2y_d;
            lx_q    <= lx_d;
            score_q <= score_d;
            // an edge on the tick cycle belongs to the next frame
            pend_q  <= flap_rise;
            if (hit) begin
              state_q <= OVER;
              over_q  <= 1'b1;
            end
          end else if (flap_rise) begin
            pend_q <= 1'b1;
          end
        end
        OVER: begin
          pend_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign plane_y     = py_q;
  assign mountain1_x = m1x_q;
  assign mountain1_y = m1y_q;
  assign mountain2_x = m2x_q;
  assign mountain2_y = m2y_q;
  assign lava_x      = lx_q;
  assign game_over   = over_q;
  assign score       = score_q;

endmodule
